// File: rtl/fft_peak_pick_two.sv
// Picks the two strongest local maxima of one positive-half FFT magnitude frame
// and reports their bin, magnitude and frequency once per frame.
module fft_peak_pick_two #(
  parameter int N_FFT        = 2048,
  parameter int MAG_W        = 28,
  parameter int BIN_W        = 11,
  parameter int MIN_BIN      = 2,
  parameter int MAG_THRESH   = 0,
  parameter int FREQ_STEP_Q8 = 62500,
  parameter int FREQ_W       = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [MAG_W-1:0]  in_mag,
  input  logic [BIN_W-1:0]  in_bin,
  output logic [BIN_W-1:0]  peak1_bin,
  output logic [MAG_W-1:0]  peak1_mag,
  output logic [FREQ_W-1:0] peak1_freq,
  output logic [BIN_W-1:0]  peak2_bin,
  output logic [MAG_W-1:0]  peak2_mag,
  output logic [FREQ_W-1:0] peak2_freq,
  output logic [1:0]        peak_count,
  output logic              result_valid,
  output logic              frame_error,
  output logic              busy
);

  localparam int HALF   = N_FFT / 2;
  localparam int PROD_W = BIN_W + 17;
  localparam logic [MAG_W-1:0]  THRESH   = MAG_W'(MAG_THRESH);
  localparam logic [BIN_W-1:0]  LAST_BIN = BIN_W'(HALF - 1);
  localparam logic [PROD_W-1:0] STEP     = PROD_W'(FREQ_STEP_Q8);

  typedef enum logic [1:0] {IDLE, COLLECT, FINAL, REPORT} state_t;
  state_t state, state_nxt;

  logic [MAG_W-1:0] m1, m2;
  logic [BIN_W-1:0] expect_bin;
  logic [BIN_W-1:0] best1_bin, best2_bin;
  logic [MAG_W-1:0] best1_mag, best2_mag;

  logic              load_frame, col_err, col_acc, is_last, is_peak;
  logic [BIN_W-1:0]  cand;
  logic [MAG_W:0]    thresh_diff;
  logic [PROD_W-1:0] prod1, prod2;

  // Sample classification for the current cycle.
  assign load_frame  = in_valid && (in_bin == '0) && (state == IDLE || state == COLLECT);
  assign col_err     = (state == COLLECT) && in_valid && (in_bin != '0) && (in_bin != expect_bin);
  assign col_acc     = (state == COLLECT) && in_valid && (in_bin != '0) && (in_bin == expect_bin);
  assign is_last     = (in_bin == LAST_BIN);
  assign cand        = in_bin - BIN_W'(1);
  // Threshold test via subtraction borrow keeps the compare meaningful for any MAG_THRESH.
  assign thresh_diff = {1'b0, m1} - {1'b0, THRESH};
  assign is_peak     = (m1 > m2) && (m1 >= in_mag) && (cand >= BIN_W'(MIN_BIN)) &&
                       !thresh_diff[MAG_W];
  assign prod1       = PROD_W'(best1_bin) * STEP;
  assign prod2       = PROD_W'(best2_bin) * STEP;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: default assignment first so no path through this block infers a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (load_frame) state_nxt = COLLECT;
      COLLECT: begin
        if (load_frame)           state_nxt = COLLECT;
        else if (col_err)         state_nxt = IDLE;
        else if (col_acc && is_last) state_nxt = FINAL;
      end
      FINAL:   state_nxt = REPORT;
      REPORT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy         = (state != IDLE);
    result_valid = (state == REPORT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m1          <= '0;
      m2          <= '0;
      expect_bin  <= '0;
      best1_bin   <= '0;
      best1_mag   <= '0;
      best2_bin   <= '0;
      best2_mag   <= '0;
      frame_error <= 1'b0;
      peak1_bin   <= '0;
      peak1_mag   <= '0;
      peak1_freq  <= '0;
      peak2_bin   <= '0;
      peak2_mag   <= '0;
      peak2_freq  <= '0;
      peak_count  <= '0;
    end else begin
      frame_error <= col_err;
      if (load_frame) begin
        best1_bin  <= '0;
        best1_mag  <= '0;
        best2_bin  <= '0;
        best2_mag  <= '0;
        m2         <= '0;
        m1         <= in_mag;
        expect_bin <= BIN_W'(1);
      end else if (col_acc) begin
        // Strict compares: on a tie the earlier bin keeps its slot.
        if (is_peak) begin
          if (m1 > best1_mag) begin
            best2_bin <= best1_bin;
            best2_mag <= best1_mag;
            best1_bin <= cand;
            best1_mag <= m1;
          end else if (m1 > best2_mag) begin
            best2_bin <= cand;
            best2_mag <= m1;
          end
        end
        m2         <= m1;
        m1         <= in_mag;
        expect_bin <= expect_bin + BIN_W'(1);
      end
      // Products are formed from the settled best slots and registered into the report.
      if (state == FINAL) begin
        peak1_bin  <= best1_bin;
        peak1_mag  <= best1_mag;
        peak1_freq <= FREQ_W'(prod1 >> 8);
        peak2_bin  <= best2_bin;
        peak2_mag  <= best2_mag;
        peak2_freq <= FREQ_W'(prod2 >> 8);
        peak_count <= {1'b0, best1_mag != '0} + {1'b0, best2_mag != '0};
      end
    end
  end

endmodule

// File: tb/tb_fft_peak_pick_two.sv
// Directed table-driven bench for fft_peak_pick_two: synthetic spectra with
// hand-computed peaks, plus missing-bin, mid-frame reset and restart sequences.
module tb_fft_peak_pick_two;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [27:0] in_mag;
  logic [10:0] in_bin;
  logic [10:0] peak1_bin, peak2_bin;
  logic [27:0] peak1_mag, peak2_mag;
  logic [19:0] peak1_freq, peak2_freq;
  logic [1:0]  peak_count;
  logic        result_valid, frame_error, busy;

  fft_peak_pick_two dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_mag(in_mag), .in_bin(in_bin),
    .peak1_bin(peak1_bin), .peak1_mag(peak1_mag), .peak1_freq(peak1_freq),
    .peak2_bin(peak2_bin), .peak2_mag(peak2_mag), .peak2_freq(peak2_freq),
    .peak_count(peak_count), .result_valid(result_valid),
    .frame_error(frame_error), .busy(busy)
  );

  always #5 clk = ~clk;

  // Spectrum: up to three nonzero (bin, mag) points, bin -1 = unused.
  typedef struct {
    int pb0, pm0, pb1, pm1, pb2, pm2;
    bit gaps;
    int e1b, e1m, e1f, e2b, e2m, e2f, ecnt;
  } vec_t;

  vec_t vecs[6];
  int   checks = 0;
  int   failures = 0;
  int   rv_cnt = 0;
  int   fe_cnt = 0;

  always @(negedge clk) begin
    if (result_valid) rv_cnt++;
    if (frame_error)  fe_cnt++;
  end

  initial begin
    #2ms;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int mag_of(input vec_t v, input int b);
    if (b == v.pb0) return v.pm0;
    if (b == v.pb1) return v.pm1;
    if (b == v.pb2) return v.pm2;
    return 0;
  endfunction

  // Drives bins 0..last_bin on consecutive negedges, optionally skipping one bin.
  task automatic run_frame(input vec_t v, input int skip_bin, input int last_bin);
    for (int b = 0; b <= last_bin; b++) begin
      if (b == skip_bin) continue;
      if (v.gaps && (b % 97) == 5) begin
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
      end
      @(negedge clk);
      in_valid = 1'b1;
      in_bin   = 11'(b);
      in_mag   = 28'(mag_of(v, b));
    end
  endtask

  // Counts negedges after the last driven bin until result_valid, bounded.
  task automatic wait_result(output int lat);
    lat = -1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 1) in_valid = 1'b0;
      if (result_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic check_peaks(input string tag, input vec_t v);
    check({tag, ".p1_bin"},  peak1_bin,  v.e1b);
    check({tag, ".p1_mag"},  peak1_mag,  v.e1m);
    check({tag, ".p1_freq"}, peak1_freq, v.e1f);
    check({tag, ".p2_bin"},  peak2_bin,  v.e2b);
    check({tag, ".p2_mag"},  peak2_mag,  v.e2m);
    check({tag, ".p2_freq"}, peak2_freq, v.e2f);
    check({tag, ".count"},   peak_count, v.ecnt);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".p1_bin"},  peak1_bin,    0);
    check({tag, ".p1_mag"},  peak1_mag,    0);
    check({tag, ".p1_freq"}, peak1_freq,   0);
    check({tag, ".p2_bin"},  peak2_bin,    0);
    check({tag, ".p2_mag"},  peak2_mag,    0);
    check({tag, ".p2_freq"}, peak2_freq,   0);
    check({tag, ".count"},   peak_count,   0);
    check({tag, ".rvalid"},  result_valid, 0);
    check({tag, ".ferr"},    frame_error,  0);
    check({tag, ".busy"},    busy,         0);
  endtask

  // Full clean frame: busy during frame, result exactly 2 cycles after bin 1023.
  task automatic clean_frame(input string tag, input vec_t v);
    int lat, rv0;
    rv0 = rv_cnt;
    run_frame(v, -1, 1023);
    check({tag, ".busy_in_frame"}, busy, 1);
    wait_result(lat);
    check({tag, ".latency"}, lat, 2);
    check_peaks(tag, v);
    @(negedge clk);
    check({tag, ".rvalid_pulse"}, result_valid, 0);
    check({tag, ".busy_after"}, busy, 0);
    check({tag, ".rv_count"}, rv_cnt - rv0, 1);
  endtask

  initial begin
    int rv0, fe0;
    // freq = bin*62500/256 truncated
    vecs[0] = '{100, 1000, 300, 500, -1, 0, 1'b0, 100, 1000, 24414, 300, 500, 73242, 2};
    vecs[1] = '{0, 9000, 1, 9000, 1023, 800, 1'b0, 0, 0, 0, 0, 0, 0, 0};
    vecs[2] = '{50, 700, 51, 700, 400, 700, 1'b0, 50, 700, 12207, 400, 700, 97656, 2};
    vecs[3] = '{2, 5, -1, 0, -1, 0, 1'b0, 2, 5, 488, 0, 0, 0, 1};
    vecs[4] = '{1022, 77, -1, 0, -1, 0, 1'b0, 1022, 77, 249511, 0, 0, 0, 1};
    vecs[5] = '{10, 300, 20, 400, 30, 350, 1'b1, 20, 400, 4882, 30, 350, 7324, 2};

    rst = 1'b1; in_valid = 1'b0; in_mag = '0; in_bin = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    // Stray nonzero bins in IDLE are ignored.
    @(negedge clk); in_valid = 1'b1; in_bin = 11'd7; in_mag = 28'd99;
    @(negedge clk); in_valid = 1'b0;
    check("idle_ignore.busy", busy, 0);

    for (int i = 0; i < 6; i++) clean_frame($sformatf("vec%0d", i), vecs[i]);

    // Missing bin 512: one error pulse, no result, previous results held.
    rv0 = rv_cnt; fe0 = fe_cnt;
    run_frame(vecs[0], 512, 513);
    @(negedge clk); in_valid = 1'b0;
    check("skip.ferr", frame_error, 1);
    check("skip.busy", busy, 0);
    @(negedge clk);
    check("skip.ferr_pulse", frame_error, 0);
    repeat (4) @(negedge clk);
    check("skip.rv_count", rv_cnt - rv0, 0);
    check("skip.fe_count", fe_cnt - fe0, 1);
    check_peaks("skip.held", vecs[5]);
    clean_frame("after_skip", vecs[0]);

    // Bin 0 mid-frame restarts without error.
    fe0 = fe_cnt;
    run_frame(vecs[5], -1, 300);
    clean_frame("restart", vecs[2]);
    check("restart.fe_count", fe_cnt - fe0, 0);

    // Reset at bin 600 abandons the frame and clears outputs.
    rv0 = rv_cnt;
    run_frame(vecs[3], -1, 600);
    @(negedge clk); in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    check_all_zero("midrst");
    rst = 1'b0;
    check("midrst.rv_count", rv_cnt - rv0, 0);
    rv0 = rv_cnt;
    clean_frame("after_rst", vecs[0]);
    repeat (4) @(negedge clk);
    check("after_rst.single_result", rv_cnt - rv0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
